// File: rtl/hatch_pkg.sv
// Shared types and constants for the hatch-stage sequencer.
package hatch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INCUBATE,
        COOL,
        HATCHED,
        DEAD
    } state_e;

    localparam int unsigned      NUM_W           = 4;
    localparam logic [NUM_W-1:0] DEAD_CODE       = 4'd15;
    localparam int unsigned      LAST_STAGE_DFLT = 11;

    // Counter width for a count of 0..limit-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/hatch_stage_ctrl_if.sv
// Button/sensor inputs and display-driver outputs of the hatch-stage sequencer.
interface hatch_stage_ctrl_if;
    import hatch_pkg::*;

    logic             start;
    logic             abort;
    logic             temp_in;
    logic [NUM_W-1:0] num;
    logic             run;
    logic             warm;
    logic             hatched;
    logic             dead;

    modport master (
        output start, abort, temp_in,
        input  num, run, warm, hatched, dead
    );

    modport slave (
        input  start, abort, temp_in,
        output num, run, warm, hatched, dead
    );
endinterface

// File: rtl/hatch_stage_ctrl_in_sync.sv
// Two-flop synchroniser for an asynchronous level, plus a one-cycle rising-edge pulse.
module in_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_lvl,
    output logic o_rise
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    // Pulse is decoded from flops so the FSM acts on the third edge after the input rises.
    assign o_lvl  = r_sync;
    assign o_rise = r_sync & ~r_prev;
endmodule

// File: rtl/hatch_stage_ctrl.sv
// Incubation sequencer: advances the hatch stage while warm, pauses while cold,
// and declares the egg dead after a sustained cold spell.
module hatch_stage_ctrl
    import hatch_pkg::*;
#(
    parameter int unsigned STAGE_CYC  = 3000,
    parameter int unsigned COLD_LIMIT = 5000,
    parameter int unsigned LAST_STAGE = LAST_STAGE_DFLT
) (
    input logic              clk,
    input logic              rst_n,
    hatch_stage_ctrl_if.slave bus
);
    localparam int unsigned      SW        = cnt_w(STAGE_CYC);
    localparam int unsigned      CW        = cnt_w(COLD_LIMIT);
    localparam logic [SW-1:0]    STAGE_TOP = SW'(STAGE_CYC - 1);
    localparam logic [CW-1:0]    COLD_TOP  = CW'(COLD_LIMIT - 1);
    localparam logic [NUM_W-1:0] NUM_LAST  = NUM_W'(LAST_STAGE);

    logic w_start_p;
    logic w_abort_p;
    logic w_warm;
    logic w_start_lvl;
    logic w_abort_lvl;
    logic w_temp_rise;
    logic w_unused;

    in_sync u_sync_start (.clk(clk), .rst_n(rst_n), .i_d(bus.start),   .o_lvl(w_start_lvl), .o_rise(w_start_p));
    in_sync u_sync_abort (.clk(clk), .rst_n(rst_n), .i_d(bus.abort),   .o_lvl(w_abort_lvl), .o_rise(w_abort_p));
    in_sync u_sync_temp  (.clk(clk), .rst_n(rst_n), .i_d(bus.temp_in), .o_lvl(w_warm),      .o_rise(w_temp_rise));

    assign w_unused = &{1'b0, w_start_lvl, w_abort_lvl, w_temp_rise};

    state_e           r_state,     w_state_nxt;
    logic [NUM_W-1:0] r_num,       w_num_nxt;
    logic             r_run,       w_run_nxt;
    logic             r_hatched,   w_hatched_nxt;
    logic             r_dead,      w_dead_nxt;
    logic [SW-1:0]    r_stage_cnt, w_stage_nxt;
    logic [CW-1:0]    r_cold_cnt,  w_cold_nxt;
    logic [NUM_W-1:0] w_num_inc;

    assign w_num_inc = r_num + NUM_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_num       <= '0;
            r_run       <= 1'b0;
            r_hatched   <= 1'b0;
            r_dead      <= 1'b0;
            r_stage_cnt <= '0;
            r_cold_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_num       <= w_num_nxt;
            r_run       <= w_run_nxt;
            r_hatched   <= w_hatched_nxt;
            r_dead      <= w_dead_nxt;
            r_stage_cnt <= w_stage_nxt;
            r_cold_cnt  <= w_cold_nxt;
        end
    end

    // Next state and next register values; abort overrides every state.
    always_comb begin
        w_state_nxt   = r_state;
        w_num_nxt     = r_num;
        w_run_nxt     = r_run;
        w_hatched_nxt = r_hatched;
        w_dead_nxt    = r_dead;
        w_stage_nxt   = r_stage_cnt;
        w_cold_nxt    = r_cold_cnt;

        if (w_abort_p) begin
            w_state_nxt   = IDLE;
            w_num_nxt     = '0;
            w_run_nxt     = 1'b0;
            w_hatched_nxt = 1'b0;
            w_dead_nxt    = 1'b0;
            w_stage_nxt   = '0;
            w_cold_nxt    = '0;
        end else begin
            case (r_state)
                IDLE, HATCHED, DEAD: begin
                    if (w_start_p) begin
                        w_state_nxt   = INCUBATE;
                        w_num_nxt     = '0;
                        w_run_nxt     = 1'b1;
                        w_hatched_nxt = 1'b0;
                        w_dead_nxt    = 1'b0;
                        w_stage_nxt   = '0;
                        w_cold_nxt    = '0;
                    end
                end
                INCUBATE, COOL: begin
                    // Every warm cycle of a run advances the stage, including the one leaving COOL.
                    if (w_warm) begin
                        w_state_nxt = INCUBATE;
                        w_cold_nxt  = '0;
                        if (r_stage_cnt == STAGE_TOP) begin
                            w_stage_nxt = '0;
                            w_num_nxt   = w_num_inc;
                            if (w_num_inc == NUM_LAST) begin
                                w_state_nxt   = HATCHED;
                                w_hatched_nxt = 1'b1;
                            end
                        end else begin
                            w_stage_nxt = r_stage_cnt + SW'(1);
                        end
                    end else if (r_state == INCUBATE) begin
                        w_state_nxt = COOL;
                        w_cold_nxt  = CW'(1);
                    end else if (r_cold_cnt == COLD_TOP) begin
                        w_state_nxt = DEAD;
                        w_num_nxt   = DEAD_CODE;
                        w_dead_nxt  = 1'b1;
                    end else begin
                        w_cold_nxt = r_cold_cnt + CW'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign bus.num     = r_num;
    assign bus.run     = r_run;
    assign bus.warm    = w_warm;
    assign bus.hatched = r_hatched;
    assign bus.dead    = r_dead;
endmodule

// File: tb/tb_hatch_stage_ctrl.sv
// Bench for hatch_stage_ctrl: directed scenarios plus random stimulus against a
// progress/cold-streak reference model compared on every cycle.
module tb_hatch_stage_ctrl;
    localparam int SC    = 4;
    localparam int CL    = 6;
    localparam int LAST  = 11;
    localparam int DEADC = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hatch_stage_ctrl_if bus();

    hatch_stage_ctrl #(
        .STAGE_CYC (SC),
        .COLD_LIMIT(CL),
        .LAST_STAGE(LAST)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a run is a count of warm cycles (progress) and a cold streak length.
    bit m_active, m_hatch, m_dead, m_warm;
    int m_prog, m_streak;
    bit s1, s2, s3, a1, a2, a3, t1, t2, t3;

    function automatic int exp_num();
        if (m_dead)   return DEADC;
        if (m_hatch)  return LAST;
        if (m_active) return m_prog / SC;
        return 0;
    endfunction

    initial begin
        bit st_p, ab_p, lvl;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active = 0; m_hatch = 0; m_dead = 0; m_warm = 0;
                m_prog = 0; m_streak = 0;
                s1 = 0; s2 = 0; s3 = 0; a1 = 0; a2 = 0; a3 = 0; t1 = 0; t2 = 0; t3 = 0;
            end else begin
                // An input seen at edge n is acted on at edge n+2; warm shows it after edge n+1.
                st_p = s2 && !s3;
                ab_p = a2 && !a3;
                lvl  = t2;
                m_warm = t1;
                if (ab_p) begin
                    m_active = 0; m_hatch = 0; m_dead = 0; m_prog = 0; m_streak = 0;
                end else if (st_p && !m_active) begin
                    m_active = 1; m_hatch = 0; m_dead = 0; m_prog = 0; m_streak = 0;
                end else if (m_active) begin
                    if (lvl) begin
                        m_streak = 0;
                        m_prog++;
                        if (m_prog == LAST * SC) begin
                            m_active = 0; m_hatch = 1;
                        end
                    end else begin
                        m_streak++;
                        if (m_streak == CL) begin
                            m_active = 0; m_dead = 1;
                        end
                    end
                end
                s3 = s2; s2 = s1; s1 = bus.start;
                a3 = a2; a2 = a1; a1 = bus.abort;
                t3 = t2; t2 = t1; t1 = bus.temp_in;
            end
        end
    end

    // Cycle-by-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("model_num",     32'(bus.num),     32'(exp_num()));
            chk("model_run",     32'(bus.run),     32'(m_active || m_hatch || m_dead));
            chk("model_warm",    32'(bus.warm),    32'(m_warm));
            chk("model_hatched", 32'(bus.hatched), 32'(m_hatch));
            chk("model_dead",    32'(bus.dead),    32'(m_dead));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int k;
        int cold_left;
        bus.start = 1'b0; bus.abort = 1'b0; bus.temp_in = 1'b0;
        cyc(3);
        chk("rst_num", 32'(bus.num), 0);
        chk("rst_run", 32'(bus.run), 0);
        chk("rst_hatched", 32'(bus.hatched), 0);
        chk("rst_dead", 32'(bus.dead), 0);
        rst_n = 1'b1;
        bus.temp_in = 1'b1;
        cyc(4);
        chk("warm_settled", 32'(bus.warm), 1);

        // Full warm run to hatch.
        bus.start = 1'b1;
        cyc(3);
        chk("start_run", 32'(bus.run), 1);
        chk("start_num", 32'(bus.num), 0);
        cyc(4);
        chk("stage1_num", 32'(bus.num), 1);
        bus.start = 1'b0;
        cyc(39);
        chk("prehatch_num", 32'(bus.num), 10);
        chk("prehatch_hatched", 32'(bus.hatched), 0);
        cyc(1);
        chk("hatch_num", 32'(bus.num), 11);
        chk("hatch_flag", 32'(bus.hatched), 1);
        bus.temp_in = 1'b0;
        cyc(8);
        chk("hatch_ignores_cold", 32'(bus.num), 11);
        bus.temp_in = 1'b1;
        cyc(4);

        // Short cold spell at num=3, stage count 2.
        bus.start = 1'b1;
        cyc(3);
        chk("restart_hatched", 32'(bus.hatched), 0);
        bus.start = 1'b0;
        cyc(12);
        bus.temp_in = 1'b0;
        cyc(2);
        chk("cold_num", 32'(bus.num), 3);
        chk("cold_warm", 32'(bus.warm), 0);
        cyc(1);
        bus.temp_in = 1'b1;
        cyc(2);
        chk("rewarm_warm", 32'(bus.warm), 1);
        chk("rewarm_num_hold", 32'(bus.num), 3);
        cyc(2);
        chk("rewarm_num_adv", 32'(bus.num), 4);
        chk("rewarm_dead", 32'(bus.dead), 0);

        // Sustained cold leads to death six cycles after warm falls.
        bus.temp_in = 1'b0;
        k = 0;
        while (bus.warm !== 1'b0 && k < 10) begin cyc(1); k++; end
        chk("warm_fall_seen", 32'(bus.warm), 0);
        k = 0;
        while (bus.dead !== 1'b1 && k < 20) begin cyc(1); k++; end
        chk("dead_latency", 32'(k), 6);
        chk("dead_num", 32'(bus.num), DEADC);
        bus.temp_in = 1'b1;
        bus.start = 1'b1;
        cyc(3);
        chk("dead_restart_num", 32'(bus.num), 0);
        chk("dead_restart_dead", 32'(bus.dead), 0);
        chk("dead_restart_run", 32'(bus.run), 1);
        bus.start = 1'b0;

        // Abort and start rising together: abort wins, no restart.
        cyc(4);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        cyc(3);
        chk("abort_run", 32'(bus.run), 0);
        chk("abort_num", 32'(bus.num), 0);
        cyc(5);
        chk("abort_no_restart", 32'(bus.run), 0);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        cyc(3);

        // Asynchronous reset mid-run at num=7.
        bus.start = 1'b1;
        cyc(3);
        bus.start = 1'b0;
        cyc(28);
        chk("pre_reset_num", 32'(bus.num), 7);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_num", 32'(bus.num), 0);
        chk("async_rst_run", 32'(bus.run), 0);
        chk("async_rst_warm", 32'(bus.warm), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(10);
        chk("post_rst_num", 32'(bus.num), 0);
        chk("post_rst_run", 32'(bus.run), 0);

        // Start pressed during a cold spell is ignored.
        bus.start = 1'b1;
        cyc(3);
        bus.start = 1'b0;
        cyc(6);
        bus.temp_in = 1'b0;
        cyc(1);
        bus.start = 1'b1;
        cyc(2);
        bus.temp_in = 1'b1;
        cyc(5);
        chk("cool_start_dead", 32'(bus.dead), 0);
        chk("cool_start_num", 32'(bus.num), 2);
        bus.start = 1'b0;
        cyc(3);

        // Randomised traffic: cold spells of varying length, occasional start and abort.
        cold_left = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (cold_left > 0) begin
                cold_left--;
                bus.temp_in = 1'b0;
            end else begin
                bus.temp_in = 1'b1;
                if ($urandom_range(0, 29) == 0) cold_left = int'($urandom_range(1, 9));
            end
            bus.start = ($urandom_range(0, 49) == 0);
            bus.abort = ($urandom_range(0, 399) == 0);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        cyc(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
